// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between the multicycle controller and the RV32I dataPath
interface multicycle_controller_if;
    logic [31:0] instr;
    logic        Zero;
    logic        cout;
    logic        overflow;
    logic        sign;
    logic        MemReady;

    logic [3:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        AdrSrc;
    logic        PCWrite;
    logic [2:0]  ImmSrc;
    logic        MemWrite;
    logic        Illegal;
    logic [3:0]  State;

    modport master (
        input  instr, Zero, cout, overflow, sign, MemReady,
        output ALUControl, ResultSrc, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
               AdrSrc, PCWrite, ImmSrc, MemWrite, Illegal, State
    );

    modport slave (
        output instr, Zero, cout, overflow, sign, MemReady,
        input  ALUControl, ResultSrc, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
               AdrSrc, PCWrite, ImmSrc, MemWrite, Illegal, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM sequencing the multicycle RV32I dataPath
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_instr_bits;

    assign opcode            = bus.instr[6:0];
    assign funct3            = bus.instr[14:12];
    assign funct7_b5         = bus.instr[30];
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    logic [3:0] alu_ctrl;
    logic [1:0] result_src;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       adr_src;
    logic       pc_write;
    logic [2:0] imm_src;
    logic       mem_write;
    logic       illegal;
    logic       branch_taken;

    // SUB is only selected by funct7[5] for register-register ops; ADDI ignores it.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic rtype);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = bus.Zero;
            3'b001:  branch_taken = ~bus.Zero;
            3'b100:  branch_taken = bus.sign ^ bus.overflow;
            3'b101:  branch_taken = ~(bus.sign ^ bus.overflow);
            3'b110:  branch_taken = ~bus.cout;
            3'b111:  branch_taken = bus.cout;
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_ctrl   = ALU_ADD;
        result_src = 2'b00;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        imm_src    = IMM_I;
        mem_write  = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.MemReady;
                pc_write   = bus.MemReady;
                if (bus.MemReady) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? MEMADR : TRAP;
                    OP_R:              state_d = EXECUTER;
                    OP_I:              state_d = EXECUTEI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? TRAP : BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = (funct3 == 3'b000) ? JALR : TRAP;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = opcode[5] ? IMM_S : IMM_I;
                state_d   = opcode[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (bus.MemReady) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.MemReady) begin
                    state_d = FETCH;
                end
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_decode(funct3, funct7_b5, 1'b1);
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_decode(funct3, funct7_b5, 1'b0);
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_write  = branch_taken;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = JAL;
            end
            LUI: begin
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
                alu_ctrl  = ALU_PASSB;
                state_d   = ALUWB;
            end
            AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
                state_d   = ALUWB;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = TRAP;
            end
        endcase
    end

    assign bus.ALUControl = alu_ctrl;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.AdrSrc     = adr_src;
    assign bus.ImmSrc     = imm_src;
    assign bus.Illegal    = illegal;
    assign bus.State      = state_q;
    // Enables are masked for the whole reset pulse, not just after the state resets.
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;

endmodule
